// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state, opcode-class and datapath select encodings for the multicycle controller
package ctrl_pkg;
  typedef enum logic [1:0] {FETCH, EXEC, MEM, WB} state_t;
  typedef enum logic [2:0] {
    CLS_ALU_REG,
    CLS_ALU_IMM,
    CLS_SHIFT,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JMP,
    CLS_ILLEGAL
  } cls_t;
  localparam logic [4:0] OP_ALU_REG = 5'b00000;
  localparam logic [4:0] OP_ALU_IMM = 5'b01000;
  localparam logic [4:0] OP_SHIFT   = 5'b11000;
  localparam logic [4:0] OP_LOAD    = 5'b10000;
  localparam logic [4:0] OP_STORE   = 5'b10001;
  localparam logic [4:0] OP_BRANCH  = 5'b10100;
  localparam logic [4:0] OP_JMP     = 5'b11100;
  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] WSEL_ALU   = 2'b00;
  localparam logic [1:0] WSEL_SHIFT = 2'b01;
  localparam logic [1:0] WSEL_MEM   = 2'b10;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: maps the 5-bit opcode field to instruction class, function code and illegal flag
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [4:0] op,
  output cls_t       cls,
  output logic [2:0] fn,
  output logic       illegal
);
  assign fn = op[2:0];
  assign cls = op[4:3] == OP_ALU_REG[4:3] ? CLS_ALU_REG
             : op[4:3] == OP_ALU_IMM[4:3] ? CLS_ALU_IMM
             : op[4:2] == OP_SHIFT[4:2]   ? CLS_SHIFT
             : op == OP_LOAD              ? CLS_LOAD
             : op == OP_STORE             ? CLS_STORE
             : op[4:2] == OP_BRANCH[4:2]  ? CLS_BRANCH
             : op == OP_JMP               ? CLS_JMP
             : CLS_ILLEGAL;
  assign illegal = cls == CLS_ILLEGAL;
endmodule

// File: rtl/mc_controller.sv
// mc_controller: FETCH/EXEC/MEM/WB multicycle control FSM with instruction register and memory-wait timeout
module mc_controller
  import ctrl_pkg::*;
#(
  parameter int INSTR_W = 19,
  parameter int TMO_W   = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instrReady,
  input  logic               zeroFlag,
  input  logic               carryFlag,
  input  logic               memReady,
  output logic               instrRead,
  output logic [1:0]         selectToWrite,
  output logic               selectR2,
  output logic               selectAluArg,
  output logic [2:0]         ALUfunction,
  output logic [1:0]         sh_roFunction,
  output logic               regWrite,
  output logic               memRead,
  output logic               memWrite,
  output logic               enableZero,
  output logic               enableCarry,
  output logic               enablePC,
  output logic [1:0]         pcSelect,
  output logic               illegal,
  output logic               memError
);
  state_t             state, state_nx;
  logic [INSTR_W-1:0] ir;
  logic [TMO_W-1:0]   cnt;
  logic               mem_fail;
  cls_t               cls;
  logic [2:0]         fn;
  logic               bad;
  logic               is_alu, is_shift, is_load, is_store, tmo, taken;
  logic               unused_operand;

  ctrl_decode u_decode (
    .op     (ir[INSTR_W-1 -: 5]),
    .cls    (cls),
    .fn     (fn),
    .illegal(bad)
  );

  assign is_alu   = cls == CLS_ALU_REG || cls == CLS_ALU_IMM;
  assign is_shift = cls == CLS_SHIFT;
  assign is_load  = cls == CLS_LOAD;
  assign is_store = cls == CLS_STORE;
  assign tmo      = &cnt;
  assign taken    = fn[1] ? carryFlag ^ fn[0] : zeroFlag ^ fn[0];
  assign unused_operand = ^ir[INSTR_W-6:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= FETCH;
      ir       <= '0;
      cnt      <= '0;
      mem_fail <= 1'b0;
    end else begin
      state    <= state_nx;
      ir       <= (state == FETCH && instrReady) ? instr : ir;
      cnt      <= (state == MEM && !memReady) ? cnt + 1'b1 : '0;
      mem_fail <= state == MEM && tmo && !memReady;
    end
  end

  // reset forces every output low even while the state register still holds MEM
  always_comb begin
    state_nx      = state;
    instrRead     = 1'b0;
    selectToWrite = WSEL_ALU;
    selectR2      = 1'b0;
    selectAluArg  = 1'b0;
    ALUfunction   = 3'b000;
    sh_roFunction = 2'b00;
    regWrite      = 1'b0;
    memRead       = 1'b0;
    memWrite      = 1'b0;
    enableZero    = 1'b0;
    enableCarry   = 1'b0;
    enablePC      = 1'b0;
    pcSelect      = PC_NEXT;
    illegal       = 1'b0;
    memError      = 1'b0;
    if (!reset)
      case (state)
        FETCH: begin
          instrRead = 1'b1;
          state_nx  = instrReady ? EXEC : FETCH;
        end
        EXEC: begin
          ALUfunction   = is_alu ? fn : 3'b000;
          sh_roFunction = is_shift ? fn[1:0] : 2'b00;
          selectAluArg  = cls == CLS_ALU_REG;
          selectR2      = is_alu;
          enableZero    = is_alu;
          enableCarry   = is_alu;
          selectToWrite = is_shift ? WSEL_SHIFT : WSEL_ALU;
          illegal       = bad;
          state_nx      = (is_load || is_store) ? MEM : WB;
        end
        MEM: begin
          memRead       = is_load && (memReady || !tmo);
          memWrite      = is_store && (memReady || !tmo);
          memError      = tmo && !memReady;
          selectToWrite = is_load ? WSEL_MEM : WSEL_ALU;
          state_nx      = (memReady || tmo) ? WB : MEM;
        end
        WB: begin
          regWrite      = is_alu || is_shift || (is_load && !mem_fail);
          enablePC      = 1'b1;
          selectToWrite = is_shift ? WSEL_SHIFT : is_load ? WSEL_MEM : WSEL_ALU;
          pcSelect      = (cls == CLS_BRANCH && taken) ? PC_BRANCH : cls == CLS_JMP ? PC_JUMP : PC_NEXT;
          state_nx      = FETCH;
        end
      endcase
  end
endmodule
